// File: rtl/fetch_if.sv
// Fetch-stage bus: ROM port, branch redirect and the decode-side valid/ready handshake.
// The master side is the fetch stage; the slave side is the ROM/branch/decode environment.
interface fetch_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        br_valid;
  logic [31:0] br_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst,
    input  rom_inst, br_valid, br_target, id_ready
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst,
    output rom_inst, br_valid, br_target, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the ROM and buffers {pc, inst} pairs
// in a small queue toward decode. A redirect flushes the queue and reloads the PC.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_BOOT | held in reset / first cycle after it; ROM disabled, pc = RESET_PC
// ST_RUN  | fetching; one push per cycle whenever the queue has room or pops
module fetch_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk_i,
  input  logic     rst_i,
  fetch_if.master  fif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        q_pc_q   [DEPTH];
  logic [31:0]        q_inst_q [DEPTH];

  logic               run;
  logic               pop;
  logic               flush;
  logic               fetch;
  logic               head_valid;

  assign run        = (state_q == ST_RUN);
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & fif.id_ready;
  assign flush      = run & fif.br_valid;
  assign fetch      = run & ~fif.br_valid & ((count_q < FULL_CNT) | pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    // A same-cycle pop still completes on a flush; decode already sampled the head.
    if (flush) begin
      pc_d    = {fif.br_target[31:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fetch) begin
        pc_d   = pc_q + 32'd4;
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(fetch) - CNT_W'(pop);
    end
  end

  // Queue storage needs no reset: the entries are only visible while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (fetch && !rst_i) begin
      q_pc_q[tail_q]   <= pc_q;
      q_inst_q[tail_q] <= fif.rom_inst;
    end
  end

  assign fif.rom_ce   = run;
  assign fif.rom_addr = pc_q;
  assign fif.id_valid = head_valid;
  assign fif.id_pc    = head_valid ? q_pc_q[head_q]   : 32'h0;
  assign fif.id_inst  = head_valid ? q_inst_q[head_q] : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed boot/backpressure/branch/wrap/reset
// scenarios plus randomized traffic, all against a queue-based reference model.
module tb_fetch_stage;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  fetch_if fif ();

  fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  assign fif.rom_inst = rom_word(fif.rom_addr);

  int checks = 0;
  int errors = 0;

  // Reference model: run flag, pc, and a queue of {pc, inst} entries.
  bit          m_run;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  function automatic logic [97:0] model_outs();
    logic [63:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 64'h0;
    return {m_run, m_pc, (m_q.size() != 0), h};
  endfunction

  function automatic logic [97:0] dut_outs();
    return {fif.rom_ce, fif.rom_addr, fif.id_valid, fif.id_pc, fif.id_inst};
  endfunction

  // Apply inputs for one cycle, advance the model, then sample 1ns after the edge.
  task automatic drive(input bit r, input bit br, input logic [31:0] tgt, input bit rdy);
    bit pop, fet;
    rst           = r;
    fif.br_valid  = br;
    fif.br_target = tgt;
    fif.id_ready  = rdy;
    if (r) begin
      m_run = 1'b0;
      m_pc  = RESET_PC;
      m_q.delete();
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      pop = (m_q.size() != 0) && rdy;
      if (br) begin
        m_q.delete();
        m_pc = {tgt[31:2], 2'b00};
      end else begin
        fet = (m_q.size() < DEPTH) || pop;
        if (pop) void'(m_q.pop_front());
        if (fet) begin
          m_q.push_back({m_pc, rom_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (dut_outs() !== {1'b0, RESET_PC, 1'b0, 64'h0}) begin
        errors++;
        $display("FAIL reset_outs got %h want %h", dut_outs(), {1'b0, RESET_PC, 1'b0, 64'h0});
      end
    end
  endtask

  task automatic test_boot();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({fif.rom_ce, fif.rom_addr, fif.id_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      errors++;
      $display("FAIL boot_edge1 got ce=%b addr=%h v=%b want ce=1 addr=%h v=0",
               fif.rom_ce, fif.rom_addr, fif.id_valid, RESET_PC);
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({fif.id_valid, fif.id_pc, fif.id_inst} !==
          {1'b1, RESET_PC + 32'(4 * k), rom_word(RESET_PC + 32'(4 * k))}) begin
        errors++;
        $display("FAIL boot_stream[%0d] got v=%b pc=%h inst=%h want pc=%h inst=%h", k,
                 fif.id_valid, fif.id_pc, fif.id_inst, RESET_PC + 32'(4 * k),
                 rom_word(RESET_PC + 32'(4 * k)));
      end
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({fif.rom_ce, fif.rom_addr, fif.id_valid, fif.id_pc, dut.count_q} !==
        {1'b1, 32'h8, 1'b1, 32'h0, 2'(DEPTH)}) begin
      errors++;
      $display("FAIL bp_frozen got ce=%b addr=%h v=%b pc=%h cnt=%0d want addr=8 pc=0 cnt=%0d",
               fif.rom_ce, fif.rom_addr, fif.id_valid, fif.id_pc, dut.count_q, DEPTH);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({fif.id_valid, fif.id_pc} !== {1'b1, 32'(4 * k)}) begin
        errors++;
        $display("FAIL bp_resume[%0d] got v=%b pc=%h want pc=%h", k,
                 fif.id_valid, fif.id_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_branch_full();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    checks++;
    if ({fif.rom_addr, fif.id_valid} !== {32'h100, 1'b0}) begin
      errors++;
      $display("FAIL brfull_redirect got addr=%h v=%b want addr=00000100 v=0",
               fif.rom_addr, fif.id_valid);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({fif.id_valid, fif.id_pc, fif.id_inst} !== {1'b1, 32'h100, rom_word(32'h100)}) begin
      errors++;
      $display("FAIL brfull_target got v=%b pc=%h inst=%h want pc=00000100",
               fif.id_valid, fif.id_pc, fif.id_inst);
    end
  endtask

  task automatic test_branch_nopop();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    checks++;
    if ({dut.count_q, fif.id_valid, fif.rom_addr} !== {2'd0, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL brnopop_flush got cnt=%0d v=%b addr=%h want cnt=0 v=0 addr=00000040",
               dut.count_q, fif.id_valid, fif.rom_addr);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({fif.id_valid, fif.id_pc} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL brnopop_first got v=%b pc=%h want pc=00000040", fif.id_valid, fif.id_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    drive(1'b0, 1'b1, 32'hFFFF_FFFA, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({fif.id_valid, fif.id_pc, fif.id_inst} !== {1'b1, exp_pc[k], rom_word(exp_pc[k])}) begin
        errors++;
        $display("FAIL wrap[%0d] got v=%b pc=%h want pc=%h", k, fif.id_valid, fif.id_pc, exp_pc[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'h0, 1'(i & 1));
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (dut_outs() !== {1'b0, RESET_PC, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL midreset_outs got %h want %h", dut_outs(), {1'b0, RESET_PC, 1'b0, 64'h0});
    end
    test_boot();
  endtask

  task automatic test_random();
    bit r, br, rdy;
    logic [31:0] tgt;
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      br  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      drive(r, br, tgt, rdy);
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++;
        $display("FAIL random[%0d] got %h want %h", n, dut_outs(), model_outs());
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    fif.br_valid  = 1'b0;
    fif.br_target = 32'h0;
    fif.id_ready  = 1'b0;
    test_reset();
    test_boot();
    test_backpressure();
    test_branch_full();
    test_branch_nopop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
